pe1_sched: RTL and testbench
============================

# pe1_sched

Pass sequencer for the PE1 butterfly datapath. It sits between the coefficient bank and PE1.
- On `start` it walks a Kyber or Dilithium NTT/INTT through `num_pass` layers.
- Every cycle it issues one read-address pair and one twiddle address.
- It drives the static PE1 mode bits for the whole run.
- It replays each address pair as a write-back `LAT` cycles later, matching PE1 pipeline depth. Between layers it drains the pipeline so the next layer never reads stale data.

## Interface
- `N_WORDS`, 128, bank depth in 24-bit words, power of two; `AW = $clog2(N_WORDS)`.
- `LAT_KNTT`, 3, PE1 latency for Kyber NTT.
- `LAT_KINTT`, 9, PE1 latency for Kyber INTT.
- `LAT_DNTT`, 3, PE1 latency for Dilithium NTT.
- `LAT_DINTT`, 4, PE1 latency for Dilithium INTT.
- `clk  in  1`  single clock, rising edge.
- `rst  in  1`  synchronous, active-high reset.
- `start  in  1`  one-cycle request; honoured only in IDLE.
- `kd  in  1`  0 = Kyber, 1 = Dilithium; latched at start.
- `inv  in  1`  0 = NTT (CT), 1 = INTT (GS); latched at start.
- `radix4  in  1`  Kyber radix-4 select; latched at start; ignored when `kd`=1.
- `num_pass  in  3`  number of layers, 0..7; latched at start.
- `busy  out  1`  high from the cycle after an accepted start until `done`.
- `done  out  1`  one-cycle pulse at run end.
- `rd_en  out  1`  read-issue strobe.
- `rd_addr_a`, `rd_addr_b`  out  AW  read address pair.
- `tw_addr  out  AW`  twiddle ROM index.
- `tw_inv  out  1`  selects the inverse twiddle table; equals the latched `inv`.
- `wr_en  out  1`  write-back strobe.
- `wr_addr_a`, `wr_addr_b`  out  AW  write-back address pair.
- `KD_mode`, `sel_1`, `sel_0`  out  1  PE1 mode bits.
- `pass_idx  out  3`  current layer `p`.

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - `start`=1 latches `kd`, `inv`, `radix4`, `num_pass`, and `LAT` (chosen by `kd`/`inv`), and clears `p` and `j`.
  - Goes to ISSUE, or to DONE if `num_pass`=0.
- ISSUE:
  - Each cycle sets `rd_en`=1 for butterfly `j` = 0..N_WORDS/2-1.
  - After `j` = N_WORDS/2-1 goes to DRAIN.
- DRAIN:
  - Waits `LAT` cycles.
  - Then `p`++, and goes to ISSUE if `p` < `num_pass`, otherwise to DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- Span `h`: `N_WORDS >> (p+1)` for NTT; `1 << p` for INTT.
- Addresses: `rd_addr_a = (j/h)*2h + (j mod h)`; `rd_addr_b = rd_addr_a + h`. `/` and `mod` are shifts and masks.
- Twiddle: `tw_addr = (1<<p) + j/h` for NTT; `(N_WORDS>>(p+1)) + j/h` for INTT.
- Mode bits, held for the whole run:
  - `KD_mode = kd`
  - `sel_1 = inv`
  - `sel_0 = radix4 & ~kd`
- Write-back: `{wr_en, wr_addr_a, wr_addr_b}` equals `{rd_en, rd_addr_a, rd_addr_b}` delayed by exactly `LAT` cycles.
- The delay line is a fixed-length pipeline at max(LAT_*) depth with a tap selected by the latched `LAT`.
- `start` while `busy`: ignored; latched fields are unchanged.
- Reset mid-run:
  - Returns to IDLE and clears the delay line, so no `wr_en` follows reset.
- Reset values: every output is 0.

## Timing
- Let an accepted start be sampled at edge `t0`.
- Pass `k` issues in cycles `t0+1+k*(N_WORDS/2+LAT)` through `+N_WORDS/2-1`.
- The final `wr_en` is at `t0+P*(N_WORDS/2+LAT)`, where P = `num_pass`.
- `done` is one cycle after the final `wr_en`; `busy` deasserts in the same cycle as `done`.
- The next `start` is accepted in the cycle after `done`.
- `rd_*` and `tw_*` are registered outputs; the bank and ROM see them one cycle before PE1 inputs are valid. `LAT` counts from `rd_en`.

## Configuration
- `PE1_SCHED_PERF_EN` defined:
  - Adds output `cycle_cnt[15:0]`.
  - Cleared at accepted start, increments every busy cycle, holds after `done`, saturates at 16'hFFFF.
- Macro undefined: no `cycle_cnt` port and no counter logic.

## Structure
- Shared package `pe1_pkg` holds:
  - the state enum
  - the default `LAT_*` constants
  - the mode-bit encoding function (`kd`, `inv`, `radix4`) -> (`KD_mode`, `sel_1`, `sel_0`)
- Sub-module `pe1_wb_delay`: parameterised depth, tap-selectable delay line for `{en, addr_a, addr_b}`, with synchronous clear.

## Test plan
- Kyber NTT, `num_pass`=7, N_WORDS=128:
  - pass 0, j=0 -> a=0, b=64, tw=1
  - pass 0, j=63 -> a=63, b=127, tw=1
  - pass 6, j=5 -> a=10, b=11, tw=69
  - `done` at `t0+470`.
- Kyber INTT, `num_pass`=7:
  - pass 0, j=0 -> a=0, b=1, tw=64, `tw_inv`=1
  - `sel_1`=1, `KD_mode`=0
  - first `wr_en` 9 cycles after first `rd_en`; `done` at `t0+512`.
- Dilithium INTT, `radix4`=1:
  - `sel_0`=0, `KD_mode`=1
  - write-back lag is 4 cycles; each `wr_addr` pair equals the `rd_addr` pair issued 4 cycles earlier.
- `num_pass`=0 -> no `rd_en`; `done` at `t0+1`.
- `start` pulsed during ISSUE with a different `kd` -> ignored; addresses and mode bits unchanged.
- `rst` asserted mid-DRAIN -> next cycle all outputs 0, no subsequent `wr_en`; a fresh start then runs normally.

Source files
------------

// File: rtl/pe1_pkg.sv
// Shared definitions for the PE1 pass sequencer: state encoding, default
// PE1 pipeline latencies and the PE1 mode-bit encoding.
package pe1_pkg;

  // Default PE1 pipeline depths per algorithm/direction
  localparam int LAT_KNTT_DEF  = 3;
  localparam int LAT_KINTT_DEF = 9;
  localparam int LAT_DNTT_DEF  = 3;
  localparam int LAT_DINTT_DEF = 4;

  // Sequencer states (kept as plain constants for legacy tools)
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ISSUE = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  typedef struct packed {
    logic kd_mode;
    logic sel_1;
    logic sel_0;
  } pe1_mode_t;

  // Static PE1 mode bits; radix-4 only exists on the Kyber datapath
  function automatic pe1_mode_t pe1_mode_bits(input logic kd, input logic inv,
                                              input logic radix4);
    pe1_mode_t m;
    m.kd_mode = kd;
    m.sel_1   = inv;
    m.sel_0   = radix4 & ~kd;
    return m;
  endfunction

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/pe1_wb_delay.sv
// Write-back delay line: a fixed DEPTH-stage shift register of
// {en, addr_a, addr_b} with the output tap chosen at run time.
// tap = n returns the input from n cycles earlier (1..DEPTH); any other
// tap value yields an idle (all-zero) output.
module pe1_wb_delay #(
  parameter int DEPTH = 9,
  parameter int AW    = 7,
  parameter int TW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          in_en,
  input  logic [AW-1:0] in_a,
  input  logic [AW-1:0] in_b,
  input  logic [TW-1:0] tap,
  output logic          out_en,
  output logic [AW-1:0] out_a,
  output logic [AW-1:0] out_b
);

  logic [DEPTH-1:0] en_sr;
  logic [AW-1:0]    a_sr [DEPTH];
  logic [AW-1:0]    b_sr [DEPTH];

  // Shift every stage by one each cycle; clear wipes all pending write-backs
  always_ff @(posedge clk) begin
    if (clr) begin
      en_sr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        a_sr[i] <= '0;
        b_sr[i] <= '0;
      end
    end else begin
      en_sr[0] <= in_en;
      a_sr[0]  <= in_a;
      b_sr[0]  <= in_b;
      for (int i = 1; i < DEPTH; i++) begin
        en_sr[i] <= en_sr[i-1];
        a_sr[i]  <= a_sr[i-1];
        b_sr[i]  <= b_sr[i-1];
      end
    end
  end

  // Tap mux with constant indices only, so any DEPTH stays lint-clean
  always_comb begin
    out_en = 1'b0;
    out_a  = '0;
    out_b  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (tap == TW'(i + 1)) begin
        out_en = en_sr[i];
        out_a  = a_sr[i];
        out_b  = b_sr[i];
      end
    end
  end

endmodule

// File: rtl/pe1_sched.sv
// PE1 pass sequencer. Walks num_pass NTT/INTT layers over an N_WORDS bank,
// issuing one butterfly address pair plus twiddle index per cycle, and
// replays each pair as a write-back LAT cycles later.
// Optional: define PE1_SCHED_PERF_EN to add the cycle_cnt run-length port.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for start; latches run configuration on start
// ISSUE    | one read pair per cycle for j = 0..N_WORDS/2-1
// DRAIN    | LAT idle cycles so the layer's write-backs land first
// DONE     | one-cycle done pulse, back to IDLE
module pe1_sched
  import pe1_pkg::*;
#(
  parameter int N_WORDS   = 128,
  parameter int LAT_KNTT  = LAT_KNTT_DEF,
  parameter int LAT_KINTT = LAT_KINTT_DEF,
  parameter int LAT_DNTT  = LAT_DNTT_DEF,
  parameter int LAT_DINTT = LAT_DINTT_DEF,
  localparam int AW       = $clog2(N_WORDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          kd,
  input  logic          inv,
  input  logic          radix4,
  input  logic [2:0]    num_pass,
  output logic          busy,
  output logic          done,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr_a,
  output logic [AW-1:0] rd_addr_b,
  output logic [AW-1:0] tw_addr,
  output logic          tw_inv,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr_a,
  output logic [AW-1:0] wr_addr_b,
  output logic          KD_mode,
  output logic          sel_1,
  output logic          sel_0,
  output logic [2:0]    pass_idx
`ifdef PE1_SCHED_PERF_EN
  ,
  output logic [15:0]   cycle_cnt
`endif
);

  localparam int DEPTH = max4(LAT_KNTT, LAT_KINTT, LAT_DNTT, LAT_DINTT);
  localparam int LW    = $clog2(DEPTH + 1);
  localparam logic [AW-2:0] J_LAST = '1;

  state_t        state;
  logic          kd_q;
  logic          inv_q;
  logic          r4_q;
  logic [2:0]    np_q;
  logic [LW-1:0] lat_q;
  logic [LW-1:0] lat_sel;
  logic [LW-1:0] drain_cnt;
  logic [2:0]    p;
  logic [AW-2:0] j;
  logic          accept;
  logic          last_pass;
  logic          wb_clr;

  int            lh;
  logic [AW-1:0] j_ext;
  logic [AW-1:0] span;
  logic [AW-1:0] hi;
  logic [AW-1:0] lo;
  logic [AW-1:0] nxt_a;
  logic [AW-1:0] nxt_b;
  logic [AW-1:0] nxt_tw;
  pe1_mode_t     mode;

  assign accept    = (state == ST_IDLE) && start;
  assign last_pass = ({1'b0, p} + 4'd1) >= {1'b0, np_q};

  // PE1 latency for the requested algorithm/direction
  always_comb begin
    lat_sel = LW'(LAT_KNTT);
    if (kd) lat_sel = inv ? LW'(LAT_DINTT) : LW'(LAT_DNTT);
    else    lat_sel = inv ? LW'(LAT_KINTT) : LW'(LAT_KNTT);
  end

  // Sequencer FSM: configuration latch, butterfly index, drain down-counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      kd_q      <= 1'b0;
      inv_q     <= 1'b0;
      r4_q      <= 1'b0;
      np_q      <= '0;
      lat_q     <= '0;
      drain_cnt <= '0;
      p         <= '0;
      j         <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            kd_q  <= kd;
            inv_q <= inv;
            r4_q  <= radix4;
            np_q  <= num_pass;
            lat_q <= lat_sel;
            p     <= '0;
            j     <= '0;
            busy  <= 1'b1;
            state <= (num_pass == 3'd0) ? ST_DONE : ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (j == J_LAST) begin
            j         <= '0;
            drain_cnt <= lat_q - LW'(1);
            state     <= ST_DRAIN;
          end else begin
            j <= j + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (drain_cnt == '0) begin
            p     <= p + 3'd1;
            state <= last_pass ? ST_DONE : ST_ISSUE;
          end else begin
            drain_cnt <= drain_cnt - LW'(1);
          end
        end
        default: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Butterfly addressing: span h = 2^lh, so j/h and j mod h are shift/mask
  always_comb begin
    lh = inv_q ? int'(p) : (AW - 1 - int'(p));
    if (lh < 0)      lh = 0;
    if (lh > AW - 1) lh = AW - 1;
    j_ext  = {1'b0, j};
    span   = AW'(1) << lh;
    hi     = j_ext >> lh;
    lo     = j_ext & (span - AW'(1));
    nxt_a  = (hi << (lh + 1)) | lo;
    nxt_b  = nxt_a + span;
    // NTT twiddle base is 2^p, INTT base is N/2^(p+1); both equal 2^(AW-1-lh)
    nxt_tw = (AW'(1) << (AW - 1 - lh)) + hi;
  end

  // Registered read/twiddle outputs, idle-zero outside ISSUE
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_en     <= 1'b0;
      rd_addr_a <= '0;
      rd_addr_b <= '0;
      tw_addr   <= '0;
    end else if (state == ST_ISSUE) begin
      rd_en     <= 1'b1;
      rd_addr_a <= nxt_a;
      rd_addr_b <= nxt_b;
      tw_addr   <= nxt_tw;
    end else begin
      rd_en     <= 1'b0;
      rd_addr_a <= '0;
      rd_addr_b <= '0;
      tw_addr   <= '0;
    end
  end

  // Clearing on start too: a longer tap than last run must not see old reads
  assign wb_clr = rst | accept;

  pe1_wb_delay #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .TW    (LW)
  ) u_wb_delay (
    .clk    (clk),
    .clr    (wb_clr),
    .in_en  (rd_en),
    .in_a   (rd_addr_a),
    .in_b   (rd_addr_b),
    .tap    (lat_q),
    .out_en (wr_en),
    .out_a  (wr_addr_a),
    .out_b  (wr_addr_b)
  );

  assign mode     = pe1_mode_bits(kd_q, inv_q, r4_q);
  assign KD_mode  = mode.kd_mode;
  assign sel_1    = mode.sel_1;
  assign sel_0    = mode.sel_0;
  assign tw_inv   = inv_q;
  assign pass_idx = p;

`ifdef PE1_SCHED_PERF_EN
  // Run-length counter: restarts on accepted start, saturates, holds after done
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt <= '0;
    end else if (accept) begin
      cycle_cnt <= '0;
    end else if (busy && (cycle_cnt != 16'hFFFF)) begin
      cycle_cnt <= cycle_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pe1_sched.sv
// Self-checking bench for pe1_sched. Expected behaviour comes from a
// closed-form model of the run timeline and butterfly arithmetic.
module tb_pe1_sched;

  localparam int NW   = 128;
  localparam int AW   = 7;
  localparam int HALF = NW / 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          kd;
  logic          inv;
  logic          radix4;
  logic [2:0]    num_pass;
  logic          busy;
  logic          done;
  logic          rd_en;
  logic [AW-1:0] rd_addr_a;
  logic [AW-1:0] rd_addr_b;
  logic [AW-1:0] tw_addr;
  logic          tw_inv;
  logic          wr_en;
  logic [AW-1:0] wr_addr_a;
  logic [AW-1:0] wr_addr_b;
  logic          KD_mode;
  logic          sel_1;
  logic          sel_0;
  logic [2:0]    pass_idx;
`ifdef PE1_SCHED_PERF_EN
  logic [15:0]   cycle_cnt;
`endif

  int checks = 0;
  int errors = 0;

  int obs_a  [0:599];
  int obs_b  [0:599];
  int obs_tw [0:599];
  bit obs_ti [0:599];
  int first_rd;
  int first_wr;
  int done_off;
  int rd_count;

  pe1_sched #(.N_WORDS(NW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .kd        (kd),
    .inv       (inv),
    .radix4    (radix4),
    .num_pass  (num_pass),
    .busy      (busy),
    .done      (done),
    .rd_en     (rd_en),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .tw_addr   (tw_addr),
    .tw_inv    (tw_inv),
    .wr_en     (wr_en),
    .wr_addr_a (wr_addr_a),
    .wr_addr_b (wr_addr_b),
    .KD_mode   (KD_mode),
    .sel_1     (sel_1),
    .sel_0     (sel_0),
    .pass_idx  (pass_idx)
`ifdef PE1_SCHED_PERF_EN
    ,
    .cycle_cnt (cycle_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic int lat_of(input bit kd_i, input bit inv_i);
    if (kd_i) return inv_i ? 4 : 3;
    return inv_i ? 9 : 3;
  endfunction

  // Offset is counted in cycles from the edge that accepted start.
  function automatic void model_rd(input int off, input bit kd_i, input bit inv_i,
                                   input int np, output bit en, output int p,
                                   output int a, output int b, output int tw);
    int per, k, r, h;
    en = 1'b0; p = 0; a = 0; b = 0; tw = 0;
    per = HALF + lat_of(kd_i, inv_i);
    if (off >= 1) begin
      k = (off - 1) / per;
      r = (off - 1) % per;
      if (k < np && r < HALF) begin
        en = 1'b1;
        p  = k;
        h  = inv_i ? (1 << k) : (NW >> (k + 1));
        a  = (r / h) * 2 * h + (r % h);
        b  = a + h;
        tw = (inv_i ? (NW >> (k + 1)) : (1 << k)) + r / h;
      end
    end
  endfunction

  function automatic logic [45:0] all_outputs();
    return {busy, done, rd_en, rd_addr_a, rd_addr_b, tw_addr, tw_inv, wr_en,
            wr_addr_a, wr_addr_b, KD_mode, sel_1, sel_0, pass_idx};
  endfunction

  // Launch one run and check every cycle until done; glitch_at >= 0 pulses
  // a conflicting start at that offset, which must have no effect.
  task automatic run_seq(input string tag, input bit kd_i, input bit inv_i,
                         input bit r4_i, input int np, input int glitch_at);
    int  L, D;
    bit  e_en, w_en;
    int  ep, ea, eb, etw, wp, wa, wb, wtw;
    L = lat_of(kd_i, inv_i);
    D = np * (HALF + L) + 1;
    kd = kd_i; inv = inv_i; radix4 = r4_i; num_pass = 3'(np); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    first_rd = -1; first_wr = -1; done_off = -1; rd_count = 0;
    for (int o = 0; o <= D; o++) begin
      if (o > 0) begin
        @(posedge clk); #1;
      end
      if (start) begin
        start = 1'b0; kd = kd_i; inv = inv_i; radix4 = r4_i; num_pass = 3'(np);
      end
      model_rd(o, kd_i, inv_i, np, e_en, ep, ea, eb, etw);
      model_rd(o - L, kd_i, inv_i, np, w_en, wp, wa, wb, wtw);
      obs_a[o] = int'(rd_addr_a); obs_b[o] = int'(rd_addr_b);
      obs_tw[o] = int'(tw_addr); obs_ti[o] = tw_inv;
      if (rd_en && first_rd < 0) first_rd = o;
      if (wr_en && first_wr < 0) first_wr = o;
      if (done && done_off < 0) done_off = o;
      if (rd_en) rd_count++;

      checks++;
      if ({busy, done} !== {o < D, o == D}) begin
        errors++;
        $display("FAIL %s busy_done off=%0d got=%b exp=%b", tag, o, {busy, done},
                 {o < D, o == D});
      end
      checks++;
      if ({KD_mode, sel_1, sel_0, tw_inv} !== {kd_i, inv_i, r4_i & ~kd_i, inv_i}) begin
        errors++;
        $display("FAIL %s mode_bits off=%0d got=%b exp=%b", tag, o,
                 {KD_mode, sel_1, sel_0, tw_inv}, {kd_i, inv_i, r4_i & ~kd_i, inv_i});
      end
      checks++;
      if (rd_en !== e_en) begin
        errors++;
        $display("FAIL %s rd_en off=%0d got=%b exp=%b", tag, o, rd_en, e_en);
      end
      if (e_en) begin
        checks++;
        if ({rd_addr_a, rd_addr_b, tw_addr, pass_idx} !==
            {AW'(ea), AW'(eb), AW'(etw), 3'(ep)}) begin
          errors++;
          $display("FAIL %s rd_addr off=%0d got a=%0d b=%0d tw=%0d p=%0d exp a=%0d b=%0d tw=%0d p=%0d",
                   tag, o, rd_addr_a, rd_addr_b, tw_addr, pass_idx, ea, eb, etw, ep);
        end
      end
      checks++;
      if (wr_en !== w_en) begin
        errors++;
        $display("FAIL %s wr_en off=%0d got=%b exp=%b", tag, o, wr_en, w_en);
      end
      if (w_en) begin
        checks++;
        if ({wr_addr_a, wr_addr_b} !== {AW'(wa), AW'(wb)}) begin
          errors++;
          $display("FAIL %s wr_addr off=%0d got a=%0d b=%0d exp a=%0d b=%0d",
                   tag, o, wr_addr_a, wr_addr_b, wa, wb);
        end
      end
      if (o == glitch_at) begin
        start = 1'b1; kd = ~kd_i; inv = 1'($urandom); radix4 = 1'($urandom);
        num_pass = 3'($urandom);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; kd = 1'b1; inv = 1'b1; radix4 = 1'b1; num_pass = 3'd5;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (all_outputs() !== '0) begin
      errors++;
      $display("FAIL reset_values got=%h exp=0", all_outputs());
    end
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (all_outputs() !== '0) begin
      errors++;
      $display("FAIL idle_after_reset got=%h exp=0", all_outputs());
    end
  endtask

  task automatic test_kyber_ntt();
    run_seq("kntt", 1'b0, 1'b0, 1'($urandom), 7, -1);
    checks++;
    if ({obs_a[1], obs_b[1], obs_tw[1]} !== {32'd0, 32'd64, 32'd1}) begin
      errors++;
      $display("FAIL kntt_p0_j0 got a=%0d b=%0d tw=%0d exp a=0 b=64 tw=1", obs_a[1], obs_b[1], obs_tw[1]);
    end
    checks++;
    if ({obs_a[64], obs_b[64], obs_tw[64]} !== {32'd63, 32'd127, 32'd1}) begin
      errors++;
      $display("FAIL kntt_p0_j63 got a=%0d b=%0d tw=%0d exp a=63 b=127 tw=1", obs_a[64], obs_b[64], obs_tw[64]);
    end
    checks++;
    if ({obs_a[408], obs_b[408], obs_tw[408]} !== {32'd10, 32'd11, 32'd69}) begin
      errors++;
      $display("FAIL kntt_p6_j5 got a=%0d b=%0d tw=%0d exp a=10 b=11 tw=69", obs_a[408], obs_b[408], obs_tw[408]);
    end
    checks++;
    if (done_off !== 470) begin
      errors++;
      $display("FAIL kntt_done_time got=%0d exp=470", done_off);
    end
  endtask

  task automatic test_kyber_intt();
    run_seq("kintt", 1'b0, 1'b1, 1'($urandom), 7, -1);
    checks++;
    if ({obs_a[1], obs_b[1], obs_tw[1]} !== {32'd0, 32'd1, 32'd64} || obs_ti[1] !== 1'b1) begin
      errors++;
      $display("FAIL kintt_p0_j0 got a=%0d b=%0d tw=%0d ti=%0d exp a=0 b=1 tw=64 ti=1",
               obs_a[1], obs_b[1], obs_tw[1], obs_ti[1]);
    end
    checks++;
    if ({sel_1, KD_mode} !== 2'b10) begin
      errors++;
      $display("FAIL kintt_mode got sel_1=%b KD_mode=%b exp sel_1=1 KD_mode=0", sel_1, KD_mode);
    end
    checks++;
    if (first_wr - first_rd !== 9) begin
      errors++;
      $display("FAIL kintt_wb_lag got=%0d exp=9", first_wr - first_rd);
    end
    checks++;
    if (done_off !== 512) begin
      errors++;
      $display("FAIL kintt_done_time got=%0d exp=512", done_off);
    end
  endtask

  task automatic test_dil_intt();
    run_seq("dintt", 1'b1, 1'b1, 1'b1, 3, -1);
    checks++;
    if ({sel_0, KD_mode} !== 2'b01) begin
      errors++;
      $display("FAIL dintt_mode got sel_0=%b KD_mode=%b exp sel_0=0 KD_mode=1", sel_0, KD_mode);
    end
    checks++;
    if (first_wr - first_rd !== 4) begin
      errors++;
      $display("FAIL dintt_wb_lag got=%0d exp=4", first_wr - first_rd);
    end
    checks++;
    if (done_off !== 205) begin
      errors++;
      $display("FAIL dintt_done_time got=%0d exp=205", done_off);
    end
  endtask

  task automatic test_zero_pass();
    run_seq("zero", 1'($urandom), 1'($urandom), 1'($urandom), 0, -1);
    checks++;
    if (rd_count !== 0 || done_off !== 1) begin
      errors++;
      $display("FAIL zero_pass got rd_count=%0d done_off=%0d exp rd_count=0 done_off=1", rd_count, done_off);
    end
  endtask

  task automatic test_start_ignored();
    run_seq("glitch_issue", 1'b0, 1'b0, 1'b1, 2, 10);
    run_seq("glitch_drain", 1'b1, 1'b0, 1'b0, 2, 66);
  endtask

  task automatic test_back_to_back();
    run_seq("b2b_0", 1'b0, 1'b0, 1'b0, 1, -1);
    run_seq("b2b_1", 1'b0, 1'b1, 1'b1, 2, -1);
    run_seq("b2b_2", 1'b1, 1'b1, 1'b0, 1, -1);
  endtask

  task automatic test_reset_mid_drain();
    kd = 1'b0; inv = 1'b0; radix4 = 1'b0; num_pass = 3'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (65) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (all_outputs() !== '0) begin
      errors++;
      $display("FAIL reset_mid_drain got=%h exp=0", all_outputs());
    end
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({wr_en, rd_en, busy, done} !== 4'b0000) begin
        errors++;
        $display("FAIL post_reset_quiet cyc=%0d got wr/rd/busy/done=%b exp=0000", i, {wr_en, rd_en, busy, done});
      end
    end
    run_seq("after_reset", 1'b0, 1'b0, 1'b0, 2, -1);
  endtask

  task automatic test_random();
    bit rk, ri, rr;
    int np, D;
    for (int it = 0; it < 8; it++) begin
      rk = 1'($urandom); ri = 1'($urandom); rr = 1'($urandom);
      np = $urandom_range(0, 7);
      D  = np * (HALF + lat_of(rk, ri)) + 1;
      run_seq("random", rk, ri, rr, np, $urandom_range(0, D - 1));
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; kd = 1'b0; inv = 1'b0; radix4 = 1'b0; num_pass = '0;
    test_reset();
    test_kyber_ntt();
    test_kyber_intt();
    test_dil_intt();
    test_zero_pass();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid_drain();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
